// File: rtl/guess_pkg.sv
// guess_pkg: controller states and guess/secret width shared with the feedback stage
package guess_pkg;
  localparam int GUESS_W = 4;
  typedef enum logic [1:0] {IDLE, READ, SHOW, DONE} state_t;
endpackage

// File: rtl/debounce.sv
// debounce: 2-FF synchronizer, stable-level counter and rising-edge press pulse
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // Any return to the accepted level before the count completes restarts it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      press <= sync[1] && !level && done;
      if (sync[1] == level) cnt <= '0;
      else if (done) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/guess_controller.sv
// guess_controller: latches a debounced guess, reads the round secret, scores it
// and holds the result for the feedback stage; tracks rounds and game end
module guess_controller
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BRAM_LAT = 1,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int NUM_ROUNDS = 16,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [GUESS_W-1:0] sw,
  input  logic btn_submit,
  input  logic [GUESS_W-1:0] bram_data,
  output logic bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [GUESS_W-1:0] player_guess,
  output logic guess_submitted,
  output logic [ADDR_W-1:0] round,
  output logic [ADDR_W:0] score,
  output logic game_over
);
  localparam int CMAX = HOLD_CYCLES > BRAM_LAT ? HOLD_CYCLES : BRAM_LAT;
  localparam int CW = $clog2(CMAX + 1);
  state_t state, state_n;
  logic press;
  logic [CW-1:0] cnt, cnt_n;
  logic [GUESS_W-1:0] guess_n;
  logic [ADDR_W-1:0] round_n;
  logic [ADDR_W:0] score_n;
  logic en_n, sub_n, over_n;
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst(rst),
    .btn(btn_submit),
    .press(press)
  );
  assign bram_addr = round;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      player_guess <= '0;
      round <= '0;
      score <= '0;
      bram_en <= 1'b0;
      guess_submitted <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      player_guess <= guess_n;
      round <= round_n;
      score <= score_n;
      bram_en <= en_n;
      guess_submitted <= sub_n;
      game_over <= over_n;
    end
  // READ spans the enable cycle plus BRAM_LAT, so the compare sees valid data
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    guess_n = player_guess;
    round_n = round;
    score_n = score;
    en_n = 1'b0;
    sub_n = guess_submitted;
    over_n = game_over;
    unique case (state)
      IDLE:
        if (press) begin
          state_n = READ;
          en_n = 1'b1;
          guess_n = sw;
          cnt_n = '0;
        end
      READ:
        if (cnt == CW'(BRAM_LAT)) begin
          state_n = SHOW;
          cnt_n = '0;
          sub_n = 1'b1;
          score_n = score + {{ADDR_W{1'b0}}, bram_data == player_guess};
        end else cnt_n = cnt + 1'b1;
      SHOW:
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          cnt_n = '0;
          sub_n = 1'b0;
          state_n = round == ADDR_W'(NUM_ROUNDS - 1) ? DONE : IDLE;
          over_n = round == ADDR_W'(NUM_ROUNDS - 1);
          round_n = round == ADDR_W'(NUM_ROUNDS - 1) ? round : round + 1'b1;
        end else cnt_n = cnt + 1'b1;
      DONE:
        if (press) begin
          state_n = IDLE;
          over_n = 1'b0;
          round_n = '0;
          score_n = '0;
          guess_n = '0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_guess_controller.sv
// tb_guess_controller: directed game scenarios plus random rounds checked against a game-level model
module tb_guess_controller;
  localparam int D = 4, L = 1, H = 8, N = 3, AW = 4;
  logic clk = 1'b0, rst = 1'b1, btn_submit = 1'b0;
  logic [3:0] sw = '0, bram_data = '0;
  logic bram_en, guess_submitted, game_over;
  logic [AW-1:0] bram_addr, round;
  logic [3:0] player_guess;
  logic [AW:0] score;
  logic [3:0] mem [16];
  int secret [N] = '{5, 9, 0};
  int en_cnt = 0, vectors = 0, errs = 0;
  int m_round = 0, m_score = 0;
  bit m_over = 0;

  always #5 clk = ~clk;

  guess_controller #(.DEBOUNCE_CYCLES(D), .BRAM_LAT(L), .HOLD_CYCLES(H), .NUM_ROUNDS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_submit(btn_submit), .bram_data(bram_data),
    .bram_en(bram_en), .bram_addr(bram_addr), .player_guess(player_guess),
    .guess_submitted(guess_submitted), .round(round), .score(score), .game_over(game_over)
  );

  initial begin
    foreach (mem[i]) mem[i] = '0;
    for (int i = 0; i < N; i++) mem[i] = 4'(secret[i]);
  end
  always @(posedge clk) if (bram_en) bram_data <= mem[bram_addr];
  always @(negedge clk) if (bram_en) en_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0: clean press, 1: bounce train then held, 2: press, early release, re-press landing in SHOW
  function automatic logic btn_at(input int mode, input int i);
    if (mode == 1) return i < 10 ? logic'((i / 2) % 2 == 0) : 1'b1;
    if (mode == 2) return i < 5 ? 1'b1 : (i < 10 ? 1'b0 : 1'b1);
    return 1'b1;
  endfunction

  task automatic play(input logic [3:0] g, input int mode);
    int base, ie, sub_len, exp_score;
    bit seen, pg_ok;
    base = en_cnt;
    seen = 0;
    ie = 0;
    sub_len = 0;
    pg_ok = 1;
    exp_score = m_score + int'(secret[m_round] == int'(g));
    sw = g;
    for (int i = 0; i < 80; i++) begin
      btn_submit = btn_at(mode, i);
      if (mode == 2 && sub_len == 3) sw = 4'd7;
      @(negedge clk);
      if (bram_en && !seen) begin
        seen = 1;
        ie = i;
        check("bram_addr", bram_addr, m_round);
        check("guess_latch", player_guess, g);
      end
      if (guess_submitted) begin
        if (sub_len == 0) begin
          check("en_to_submit", i - ie, L + 1);
          check("score_first_show", score, exp_score);
        end
        if (player_guess !== g || bram_en) pg_ok = 0;
        sub_len++;
      end else if (sub_len > 0) break;
    end
    check("bram_en_seen", seen, 1);
    check("hold_len", sub_len, H);
    check("show_frozen", pg_ok, 1);
    btn_submit = 1'b0;
    repeat (12) @(negedge clk);
    m_score = exp_score;
    if (m_round == N - 1) m_over = 1;
    else m_round++;
    check("single_bram_en", en_cnt - base, 1);
    check("round", round, m_round);
    check("score", score, m_score);
    check("game_over", game_over, m_over);
  endtask

  task automatic done_press();
    int base;
    base = en_cnt;
    btn_submit = 1'b1;
    repeat (12) @(negedge clk);
    check("done_over_clr", game_over, 0);
    check("done_round_clr", round, 0);
    check("done_score_clr", score, 0);
    check("done_guess_clr", player_guess, 0);
    check("done_no_en", en_cnt - base, 0);
    btn_submit = 1'b0;
    repeat (12) @(negedge clk);
    m_round = 0;
    m_score = 0;
    m_over = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bram_en", bram_en, 0);
    check("rst_submitted", guess_submitted, 0);
    check("rst_game_over", game_over, 0);
    check("rst_guess", player_guess, 0);
    check("rst_round", round, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_score", score, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    play(4'd5, 0);
    play(4'd3, 2);
    play(4'd0, 1);
    done_press();
    sw = 4'd5;
    btn_submit = 1'b1;
    for (int i = 0; i < 40 && !guess_submitted; i++) @(negedge clk);
    check("pre_rst_submitted", guess_submitted, 1);
    repeat (3) @(negedge clk);
    check("pre_rst_score", score, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_submitted", guess_submitted, 0);
    check("async_rst_round", round, 0);
    check("async_rst_score", score, 0);
    check("async_rst_guess", player_guess, 0);
    check("async_rst_over", game_over, 0);
    @(negedge clk);
    btn_submit = 1'b0;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    m_round = 0;
    m_score = 0;
    m_over = 0;
    play(4'd5, 0);
    for (int k = 0; k < 10; k++) begin
      if (m_over) done_press();
      else play($urandom_range(0, 1) ? 4'(secret[m_round]) : 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
